// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//   Signal bundle between one raw push-button source and its conditioner.
//   Signals:
//     button_i         raw, asynchronous, possibly bouncing button level
//     pressed_o        debounced, stable button level
//     press_pulse_o    one-cycle pulse on initial press or auto-repeat
//     repeat_o         qualifies press_pulse_o as an auto-repeat
//     release_pulse_o  one-cycle pulse on debounced release
//     state_o          conditioner FSM state (0 IDLE, 1 HOLD, 2 REPEAT)
//   Modports:
//     master  the side that owns the button and consumes the events
//     slave   the conditioner itself
// ---------------------------------------------------------------------------
interface button_conditioner_if;
    logic       button_i;
    logic       pressed_o;
    logic       press_pulse_o;
    logic       repeat_o;
    logic       release_pulse_o;
    logic [1:0] state_o;

    modport master (
        output button_i,
        input  pressed_o,
        input  press_pulse_o,
        input  repeat_o,
        input  release_pulse_o,
        input  state_o
    );

    modport slave (
        input  button_i,
        output pressed_o,
        output press_pulse_o,
        output repeat_o,
        output release_pulse_o,
        output state_o
    );
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Turns one raw push-button into clean single-cycle events: a press pulse,
//   auto-repeat pulses while held (delayed auto shift), and a release pulse.
//   The raw level is synchronised by two flops, then debounced: the stable
//   level only follows the synchronised level after it has differed for
//   DEBOUNCE_CYCLES consecutive edges.
//   Ports:
//     clk    system clock, all state on the rising edge
//     rst_i  asynchronous, active-high reset
//     btn    button_conditioner_if.slave (button_i in, conditioned events out)
//   Parameters:
//     DEBOUNCE_CYCLES  edges the new level must persist before acceptance
//     HOLD_CYCLES      edges from the press pulse to the first auto-repeat
//     REPEAT_CYCLES    edges between successive auto-repeats
//     REPEAT_EN        1 enables auto-repeat, 0 gives one pulse per press
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int REPEAT_CYCLES   = 3,
    parameter bit REPEAT_EN       = 1'b1
) (
    input logic                 clk,
    input logic                 rst_i,
    button_conditioner_if.slave btn
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO    = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Synchroniser and debounce state
    logic             sync_meta_r;
    logic             sync_q_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             accept_s;
    logic             rise_s;
    logic             fall_s;

    // FSM, timer and registered event outputs
    state_t           state_r;
    state_t           state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    logic             press_r;
    logic             press_nxt_s;
    logic             repeat_r;
    logic             repeat_nxt_s;
    logic             release_r;
    logic             release_nxt_s;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync_meta_r <= 1'b0;
            sync_q_r    <= 1'b0;
        end else begin
            sync_meta_r <= btn.button_i;
            sync_q_r    <= sync_meta_r;
        end
    end

    // Debounce decision: count consecutive disagreeing edges, accept on the last one
    always_comb begin
        cnt_nxt_s = CNT_ZERO;
        accept_s  = 1'b0;
        if (sync_q_r != stable_r) begin
            if (cnt_r == CNT_LAST) begin
                accept_s  = 1'b1;
                cnt_nxt_s = CNT_ZERO;
            end else begin
                accept_s  = 1'b0;
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            accept_s  = 1'b0;
            cnt_nxt_s = CNT_ZERO;
        end
    end

    // The accepted edge is decoded here so the FSM reacts on the same edge
    // that updates the stable level, keeping pressed_o and the pulses aligned.
    assign rise_s = accept_s & ~stable_r;
    assign fall_s = accept_s &  stable_r;

    // Debounce counter and stable level register
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            if (accept_s) begin
                stable_r <= sync_q_r;
            end else begin
                stable_r <= stable_r;
            end
        end
    end

    // Next-state, timer and pulse decode for the press/hold/repeat FSM
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        press_nxt_s   = 1'b0;
        repeat_nxt_s  = 1'b0;
        release_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    press_nxt_s = 1'b1;
                    timer_nxt_s = TMR_ZERO;
                    state_nxt_s = ST_HOLD;
                end else begin
                    timer_nxt_s = TMR_ZERO;
                end
            end
            ST_HOLD: begin
                // Release has priority over any repeat falling due this edge.
                if (fall_s) begin
                    release_nxt_s = 1'b1;
                    timer_nxt_s   = TMR_ZERO;
                    state_nxt_s   = ST_IDLE;
                end else if (timer_r == HOLD_LAST) begin
                    if (REPEAT_EN) begin
                        press_nxt_s  = 1'b1;
                        repeat_nxt_s = 1'b1;
                        timer_nxt_s  = TMR_ZERO;
                        state_nxt_s  = ST_REPEAT;
                    end else begin
                        // Without auto-repeat the timer parks at its last value.
                        timer_nxt_s = timer_r;
                    end
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
            end
            ST_REPEAT: begin
                if (fall_s) begin
                    release_nxt_s = 1'b1;
                    timer_nxt_s   = TMR_ZERO;
                    state_nxt_s   = ST_IDLE;
                end else if (timer_r == REPEAT_LAST) begin
                    press_nxt_s  = 1'b1;
                    repeat_nxt_s = 1'b1;
                    timer_nxt_s  = TMR_ZERO;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = TMR_ZERO;
            end
        endcase
    end

    // FSM state, timer and registered pulse outputs
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            timer_r   <= TMR_ZERO;
            press_r   <= 1'b0;
            repeat_r  <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            press_r   <= press_nxt_s;
            repeat_r  <= repeat_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    assign btn.pressed_o       = stable_r;
    assign btn.press_pulse_o   = press_r;
    assign btn.repeat_o        = repeat_r;
    assign btn.release_pulse_o = release_r;
    assign btn.state_o         = state_r;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//   Drives two conditioners (auto-repeat on and off) from one button level.
//   A behavioural model derives the expected outputs from the button sample
//   history and the press edge index; a per-cycle compare checks both DUTs,
//   and directed literal checks pin the key edges of each scenario.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int REP  = 3;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic button = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    button_conditioner_if bif0 ();
    button_conditioner_if bif1 ();

    assign bif0.button_i = button;
    assign bif1.button_i = button;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk), .rst_i(rst), .btn(bif0)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)
    ) dut_norep (
        .clk(clk), .rst_i(rst), .btn(bif1)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Stable level flips once the last DEB button samples seen through the
    // two-edge synchroniser all disagree with it. Pulses follow from the index
    // of the press edge: P, then P+HOLD, then every REP edges.
    bit       samp_q[$];
    bit       dly_q[$];
    bit       m_stable = 1'b0;
    int       m_n      = 0;
    int       m_p      = 0;
    bit       m_d;
    bit       m_flip;
    bit       e_press[2];
    bit       e_rep[2];
    bit       e_rel[2];
    int       e_state[2];

    // Model update on every active edge, cleared by reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q.delete();
            dly_q.delete();
            m_stable = 1'b0;
            m_n      = 0;
            m_p      = 0;
            for (int m = 0; m < 2; m++) begin
                e_press[m] = 1'b0;
                e_rep[m]   = 1'b0;
                e_rel[m]   = 1'b0;
                e_state[m] = 0;
            end
        end else begin
            m_d = (samp_q.size() >= 2) ? samp_q[samp_q.size() - 2] : 1'b0;
            samp_q.push_back(button);
            if (samp_q.size() > 4) void'(samp_q.pop_front());
            dly_q.push_back(m_d);
            if (dly_q.size() > DEB) void'(dly_q.pop_front());
            m_flip = (dly_q.size() == DEB);
            foreach (dly_q[i]) if (dly_q[i] == m_stable) m_flip = 1'b0;
            m_n++;
            if (m_flip) begin
                m_stable = !m_stable;
                if (m_stable) m_p = m_n;
            end
            for (int m = 0; m < 2; m++) begin
                e_press[m] = 1'b0;
                e_rep[m]   = 1'b0;
                e_rel[m]   = 1'b0;
                if (m_flip && m_stable) begin
                    e_press[m] = 1'b1;
                end else if (m_flip) begin
                    e_rel[m] = 1'b1;
                end else if (m_stable && (m == 0) && (m_n >= m_p + HOLD)
                             && (((m_n - m_p - HOLD) % REP) == 0)) begin
                    e_press[m] = 1'b1;
                    e_rep[m]   = 1'b1;
                end
                if (!m_stable)                               e_state[m] = 0;
                else if ((m == 0) && (m_n >= m_p + HOLD))    e_state[m] = 2;
                else                                         e_state[m] = 1;
            end
        end
    end

    // Per-cycle compare of both DUTs against the model, away from the active edge
    always @(negedge clk) begin
        check("pressed",         int'(bif0.pressed_o),       int'(m_stable));
        check("press_pulse",     int'(bif0.press_pulse_o),   int'(e_press[0]));
        check("repeat",          int'(bif0.repeat_o),        int'(e_rep[0]));
        check("release_pulse",   int'(bif0.release_pulse_o), int'(e_rel[0]));
        check("state",           int'(bif0.state_o),         e_state[0]);
        check("nr_pressed",      int'(bif1.pressed_o),       int'(m_stable));
        check("nr_press_pulse",  int'(bif1.press_pulse_o),   int'(e_press[1]));
        check("nr_repeat",       int'(bif1.repeat_o),        int'(e_rep[1]));
        check("nr_release_pulse",int'(bif1.release_pulse_o), int'(e_rel[1]));
        check("nr_state",        int'(bif1.state_o),         e_state[1]);
    end

    // Pulse counters, sampled just after each active edge
    int press_cnt0 = 0;
    int press_cnt1 = 0;
    int rel_cnt0   = 0;
    always @(posedge clk) begin
        #1;
        if (bif0.press_pulse_o === 1'b1)   press_cnt0++;
        if (bif1.press_pulse_o === 1'b1)   press_cnt1++;
        if (bif0.release_pulse_o === 1'b1) rel_cnt0++;
    end

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    int c0;
    int c1;
    int r0;

    // Directed scenarios with hand-computed expectations
    initial begin
        rst    = 1'b1;
        button = 1'b0;
        step(3);
        check("rst_pressed", int'(bif0.pressed_o), 0);
        check("rst_state",   int'(bif0.state_o),   0);
        rst = 1'b0;

        // 1: three-cycle glitch is filtered
        c0 = press_cnt0;
        button = 1'b1;
        step(3);
        button = 1'b0;
        step(10);
        check("glitch_pulses",  press_cnt0 - c0,          0);
        check("glitch_pressed", int'(bif0.pressed_o),     0);
        check("glitch_state",   int'(bif0.state_o),       0);

        // 2 and 3: hold 20 cycles then release
        c0 = press_cnt0;
        c1 = press_cnt1;
        button = 1'b1;
        step(5);
        check("e5_pressed", int'(bif0.pressed_o), 0);
        step(1);
        check("e6_pressed", int'(bif0.pressed_o),     1);
        check("e6_press",   int'(bif0.press_pulse_o), 1);
        check("e6_repeat",  int'(bif0.repeat_o),      0);
        check("e6_state",   int'(bif0.state_o),       1);
        step(7);
        check("e13_press",  int'(bif0.press_pulse_o), 0);
        check("e13_state",  int'(bif0.state_o),       1);
        step(1);
        check("e14_press",  int'(bif0.press_pulse_o), 1);
        check("e14_repeat", int'(bif0.repeat_o),      1);
        check("e14_state",  int'(bif0.state_o),       2);
        step(3);
        check("e17_press",  int'(bif0.press_pulse_o), 1);
        check("e17_repeat", int'(bif0.repeat_o),      1);
        step(3);
        button = 1'b0;
        step(3);
        check("f3_press",   int'(bif0.press_pulse_o), 1);
        step(2);
        check("f5_pressed", int'(bif0.pressed_o),       1);
        check("f5_release", int'(bif0.release_pulse_o), 0);
        step(1);
        check("f6_release", int'(bif0.release_pulse_o), 1);
        check("f6_press",   int'(bif0.press_pulse_o),   0);
        check("f6_pressed", int'(bif0.pressed_o),       0);
        check("f6_state",   int'(bif0.state_o),         0);
        check("nr_f6_release", int'(bif1.release_pulse_o), 1);
        step(10);
        check("hold_pulses",    press_cnt0 - c0, 5);
        check("nr_hold_pulses", press_cnt1 - c1, 1);

        // 4: bounce before settling high
        c0 = press_cnt0;
        button = 1'b1; step(1);
        button = 1'b0; step(1);
        button = 1'b1; step(1);
        button = 1'b0; step(1);
        button = 1'b1;
        step(5);
        check("bounce_e5_press", int'(bif0.press_pulse_o), 0);
        step(1);
        check("bounce_e6_press", int'(bif0.press_pulse_o), 1);
        step(4);
        check("bounce_pulses", press_cnt0 - c0, 1);
        button = 1'b0;
        step(10);

        // 5: reset while repeating
        button = 1'b1;
        step(15);
        check("pre_rst_state", int'(bif0.state_o), 2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_now_pressed", int'(bif0.pressed_o),       0);
        check("rst_now_press",   int'(bif0.press_pulse_o),   0);
        check("rst_now_repeat",  int'(bif0.repeat_o),        0);
        check("rst_now_release", int'(bif0.release_pulse_o), 0);
        check("rst_now_state",   int'(bif0.state_o),         0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(5);
        check("post_rst_e5_press", int'(bif0.press_pulse_o), 0);
        step(1);
        check("post_rst_e6_press", int'(bif0.press_pulse_o), 1);
        check("post_rst_e6_state", int'(bif0.state_o),       1);
        button = 1'b0;
        step(12);

        // 6: long hold, auto-repeat disabled instance
        c1 = press_cnt1;
        r0 = rel_cnt0;
        button = 1'b1;
        step(30);
        check("nr_long_pulses",  press_cnt1 - c1,       1);
        check("nr_long_state",   int'(bif1.state_o),    1);
        check("nr_long_pressed", int'(bif1.pressed_o),  1);
        button = 1'b0;
        step(5);
        check("nr_f5_release", int'(bif1.release_pulse_o), 0);
        step(1);
        check("nr_f6_release", int'(bif1.release_pulse_o), 1);
        check("nr_f6_state",   int'(bif1.state_o),         0);
        check("nr_f6_pressed", int'(bif1.pressed_o),       0);
        step(5);
        check("long_releases", rel_cnt0 - r0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
